// File: rtl/uart_regs_pkg.sv
// uart_regs_pkg: register offsets, bit indices, reset constants and the
// parity encoding shared by the UART APB register file and its interrupt
// controller.
package uart_regs_pkg;

    // Register byte offsets (word aligned)
    localparam int unsigned OFF_DATA     = 32'h00;
    localparam int unsigned OFF_CTRL     = 32'h04;
    localparam int unsigned OFF_STAT     = 32'h08;
    localparam int unsigned OFF_INT_STAT = 32'h0C;
    localparam int unsigned OFF_INT_EN   = 32'h10;
    localparam int unsigned OFF_BAUD     = 32'h14;
    localparam int unsigned OFF_FIFO_THR = 32'h18;

    // CTRL fields
    localparam int unsigned CTRL_W       = 6;
    localparam int unsigned CTRL_UART_EN = 0;
    localparam int unsigned CTRL_TX_EN   = 1;
    localparam int unsigned CTRL_RX_EN   = 2;
    localparam int unsigned CTRL_PAR_LSB = 3;
    localparam int unsigned CTRL_STOP    = 5;

    // STAT fields
    localparam int unsigned STAT_RX_EMPTY = 0;
    localparam int unsigned STAT_TX_FULL  = 1;
    localparam int unsigned STAT_RX_BUSY  = 2;
    localparam int unsigned STAT_TX_BUSY  = 3;
    localparam int unsigned STAT_RX_LVL   = 8;
    localparam int unsigned STAT_TX_LVL   = 16;

    // INT_STAT / INT_EN bits
    localparam int unsigned INT_W       = 6;
    localparam int unsigned INT_RX_DONE = 0;
    localparam int unsigned INT_TX_DONE = 1;
    localparam int unsigned INT_RX_ERR  = 2;
    localparam int unsigned INT_RX_THR  = 3;
    localparam int unsigned INT_TX_THR  = 4;
    localparam int unsigned INT_APB_ERR = 5;

    // FIFO_THR field positions
    localparam int unsigned THR_TX_LSB = 16;

    localparam logic [15:0] BAUD_RST = 16'h001B;

    // parity_mode encoding; the reserved code is treated as no parity
    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2,
        PARITY_RSVD = 2'd3
    } parity_e;

    // Decoded register select
    typedef enum logic [2:0] {
        SEL_DATA, SEL_CTRL, SEL_STAT, SEL_INT_STAT,
        SEL_INT_EN, SEL_BAUD, SEL_FIFO_THR, SEL_NONE
    } reg_sel_e;

endpackage

// File: rtl/uart_int_ctrl.sv
// uart_int_ctrl: INT_STAT / INT_EN registers and the registered irq.
// Ports: clk_i/rst_i (sync, active-high); event pulses rx_done_i, tx_done_i,
// rx_error_i, apb_err_i; FIFO levels and thresholds for the level bits;
// stat_we_i (W1C) / en_we_i with wdata_i; uart_en_i gate; int_stat_o,
// int_en_o, irq_o.
module uart_int_ctrl
    import uart_regs_pkg::*;
#(
    parameter int unsigned LW = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rx_done_i,
    input  logic             tx_done_i,
    input  logic             rx_error_i,
    input  logic             apb_err_i,
    input  logic [LW-1:0]    rx_level_i,
    input  logic [LW-1:0]    tx_level_i,
    input  logic [LW-1:0]    rx_thr_i,
    input  logic [LW-1:0]    tx_thr_i,
    input  logic             stat_we_i,
    input  logic             en_we_i,
    input  logic [INT_W-1:0] wdata_i,
    input  logic             uart_en_i,
    output logic [INT_W-1:0] int_stat_o,
    output logic [INT_W-1:0] int_en_o,
    output logic             irq_o
);

    logic [INT_W-1:0] stat_q, stat_d, en_q, en_d, set, clr;
    logic             irq_q, irq_d;

    // Sticky bits: set beats a same-cycle W1C; level bits just track compares
    always_comb begin
        set                = '0;
        set[INT_RX_DONE]   = rx_done_i;
        set[INT_TX_DONE]   = tx_done_i;
        set[INT_RX_ERR]    = rx_error_i;
        set[INT_APB_ERR]   = apb_err_i;
        clr                = stat_we_i ? wdata_i : '0;
        stat_d             = (stat_q & ~clr) | set;
        stat_d[INT_RX_THR] = (rx_level_i >= rx_thr_i);
        stat_d[INT_TX_THR] = (tx_level_i <= tx_thr_i);
        en_d               = en_we_i ? wdata_i : en_q;
        irq_d              = (|(stat_q & en_q)) & uart_en_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_q <= '0;
            en_q   <= '0;
            irq_q  <= 1'b0;
        end else begin
            stat_q <= stat_d;
            en_q   <= en_d;
            irq_q  <= irq_d;
        end
    end

    assign int_stat_o = stat_q;
    assign int_en_o   = en_q;
    assign irq_o      = irq_q;

endmodule

// File: rtl/uart_apb_regfile.sv
// uart_apb_regfile: APB3 register file for the UART subsystem.
// Ports: APB slave (PCLK, PRESET sync active-high, PADDR, PSEL, PENABLE,
// PWRITE, PWDATA, PREADY, PRDATA, PSLVERR); TX FIFO push (tx_full,
// tx_level, tx_wr_en, tx_wdata); RX FIFO pop (rx_empty, rx_level, rx_rdata,
// rx_rd_en); framer status/events; CTRL/BAUD configuration outputs; irq.
module uart_apb_regfile
    import uart_regs_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned FIFO_AW      = 4,
    parameter int unsigned WAIT_TIMEOUT = 15
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PREADY,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PSLVERR,
    input  logic                  tx_full,
    input  logic [FIFO_AW:0]      tx_level,
    output logic                  tx_wr_en,
    output logic [7:0]            tx_wdata,
    input  logic                  rx_empty,
    input  logic [FIFO_AW:0]      rx_level,
    input  logic [7:0]            rx_rdata,
    output logic                  rx_rd_en,
    input  logic                  rx_done,
    input  logic                  tx_done,
    input  logic                  rx_error,
    input  logic                  rx_busy,
    input  logic                  tx_busy,
    output logic                  uart_en,
    output logic                  tx_en,
    output logic                  rx_en,
    output logic [1:0]            parity_mode,
    output logic                  stop_bits,
    output logic [15:0]           baud_div,
    output logic                  irq
);

    localparam int unsigned LW  = FIFO_AW + 1;
    localparam int unsigned WCW = 8;

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [15:0]       baud_q, baud_d;
    logic [LW-1:0]     rx_thr_q, rx_thr_d, tx_thr_q, tx_thr_d;
    logic [WCW-1:0]    wait_cnt_q, wait_cnt_d;
    logic [INT_W-1:0]  int_stat, int_en;
    logic [DATA_WIDTH-1:0] rdata;
    reg_sel_e          sel;
    logic access, is_data, fifo_blk, stall, timeout, data_ok, wr_ok;
    logic unused_pwdata;

    assign unused_pwdata = ^PWDATA;

    // Address decode; misaligned and unmapped offsets fall to SEL_NONE
    always_comb begin
        sel = SEL_NONE;
        case (PADDR)
            ADDR_WIDTH'(OFF_DATA):     sel = SEL_DATA;
            ADDR_WIDTH'(OFF_CTRL):     sel = SEL_CTRL;
            ADDR_WIDTH'(OFF_STAT):     sel = SEL_STAT;
            ADDR_WIDTH'(OFF_INT_STAT): sel = SEL_INT_STAT;
            ADDR_WIDTH'(OFF_INT_EN):   sel = SEL_INT_EN;
            ADDR_WIDTH'(OFF_BAUD):     sel = SEL_BAUD;
            ADDR_WIDTH'(OFF_FIFO_THR): sel = SEL_FIFO_THR;
            default:                   sel = SEL_NONE;
        endcase
    end

    assign access   = PSEL & PENABLE;
    assign is_data  = access & (sel == SEL_DATA);
    assign fifo_blk = PWRITE ? tx_full : rx_empty;
    assign stall    = is_data & fifo_blk;
    assign timeout  = stall & (wait_cnt_q == WCW'(WAIT_TIMEOUT));
    assign data_ok  = is_data & ~fifo_blk;
    assign wr_ok    = access & PWRITE & ~PRESET;

    // Read data mux
    always_comb begin
        rdata = '0;
        case (sel)
            SEL_DATA:     rdata[7:0] = rx_rdata;
            SEL_CTRL:     rdata[CTRL_W-1:0] = ctrl_q;
            SEL_STAT: begin
                rdata[STAT_RX_EMPTY]      = rx_empty;
                rdata[STAT_TX_FULL]       = tx_full;
                rdata[STAT_RX_BUSY]       = rx_busy;
                rdata[STAT_TX_BUSY]       = tx_busy;
                rdata[STAT_RX_LVL +: LW]  = rx_level;
                rdata[STAT_TX_LVL +: LW]  = tx_level;
            end
            SEL_INT_STAT: rdata[INT_W-1:0] = int_stat;
            SEL_INT_EN:   rdata[INT_W-1:0] = int_en;
            SEL_BAUD:     rdata[15:0] = baud_q;
            SEL_FIFO_THR: begin
                rdata[LW-1:0]            = rx_thr_q;
                rdata[THR_TX_LSB +: LW]  = tx_thr_q;
            end
            default:      rdata = '0;
        endcase
    end

    // APB response and FIFO strobes; reset abandons any in-flight transfer
    always_comb begin
        PREADY   = 1'b1;
        PSLVERR  = 1'b0;
        PRDATA   = '0;
        tx_wr_en = 1'b0;
        tx_wdata = '0;
        rx_rd_en = 1'b0;
        if (!PRESET && access) begin
            PREADY  = ~stall | timeout;
            PSLVERR = (sel == SEL_NONE) | timeout;
            if (data_ok) begin
                tx_wr_en = PWRITE;
                tx_wdata = PWRITE ? PWDATA[7:0] : 8'h00;
                rx_rd_en = ~PWRITE;
            end
            if (!PWRITE && PREADY && !PSLVERR) PRDATA = rdata;
        end
    end

    // Register next-state; BAUD ignores a zero write
    always_comb begin
        ctrl_d     = ctrl_q;
        baud_d     = baud_q;
        rx_thr_d   = rx_thr_q;
        tx_thr_d   = tx_thr_q;
        wait_cnt_d = wait_cnt_q;
        if (wr_ok) begin
            case (sel)
                SEL_CTRL: ctrl_d = PWDATA[CTRL_W-1:0];
                SEL_BAUD: if (PWDATA[15:0] != 16'h0000) baud_d = PWDATA[15:0];
                SEL_FIFO_THR: begin
                    rx_thr_d = PWDATA[LW-1:0];
                    tx_thr_d = PWDATA[THR_TX_LSB +: LW];
                end
                default: ;
            endcase
        end
        if (!PSEL || (access && PREADY)) wait_cnt_d = '0;
        else if (stall)                  wait_cnt_d = wait_cnt_q + WCW'(1);
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            ctrl_q     <= '0;
            baud_q     <= BAUD_RST;
            rx_thr_q   <= LW'(1);
            tx_thr_q   <= '0;
            wait_cnt_q <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            baud_q     <= baud_d;
            rx_thr_q   <= rx_thr_d;
            tx_thr_q   <= tx_thr_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    uart_int_ctrl #(.LW(LW)) u_int_ctrl (
        .clk_i      (PCLK),
        .rst_i      (PRESET),
        .rx_done_i  (rx_done),
        .tx_done_i  (tx_done),
        .rx_error_i (rx_error),
        .apb_err_i  (access & PSLVERR),
        .rx_level_i (rx_level),
        .tx_level_i (tx_level),
        .rx_thr_i   (rx_thr_q),
        .tx_thr_i   (tx_thr_q),
        .stat_we_i  (wr_ok & (sel == SEL_INT_STAT)),
        .en_we_i    (wr_ok & (sel == SEL_INT_EN)),
        .wdata_i    (PWDATA[INT_W-1:0]),
        .uart_en_i  (ctrl_q[CTRL_UART_EN]),
        .int_stat_o (int_stat),
        .int_en_o   (int_en),
        .irq_o      (irq)
    );

    assign uart_en     = ctrl_q[CTRL_UART_EN];
    assign tx_en       = ctrl_q[CTRL_TX_EN];
    assign rx_en       = ctrl_q[CTRL_RX_EN];
    assign parity_mode = ctrl_q[CTRL_PAR_LSB +: 2];
    assign stop_bits   = ctrl_q[CTRL_STOP];
    assign baud_div    = baud_q;

endmodule

// File: tb/tb_uart_apb_regfile.sv
// tb_uart_apb_regfile: directed self-checking bench for uart_apb_regfile.
module tb_uart_apb_regfile;

    logic        PCLK, PRESET;
    logic [7:0]  PADDR;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PWDATA, PRDATA;
    logic        PREADY, PSLVERR;
    logic        tx_full, rx_empty, tx_wr_en, rx_rd_en;
    logic [4:0]  tx_level, rx_level;
    logic [7:0]  tx_wdata, rx_rdata;
    logic        rx_done, tx_done, rx_error, rx_busy, tx_busy;
    logic        uart_en, tx_en, rx_en, stop_bits, irq;
    logic [1:0]  parity_mode;
    logic [15:0] baud_div;

    int n_checks = 0;
    int n_errors = 0;
    int tx_cnt   = 0;
    int rx_cnt   = 0;
    logic [7:0] last_wd = 8'h00;

    uart_apb_regfile dut (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSEL(PSEL),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
        .tx_full(tx_full), .tx_level(tx_level), .tx_wr_en(tx_wr_en),
        .tx_wdata(tx_wdata), .rx_empty(rx_empty), .rx_level(rx_level),
        .rx_rdata(rx_rdata), .rx_rd_en(rx_rd_en), .rx_done(rx_done),
        .tx_done(tx_done), .rx_error(rx_error), .rx_busy(rx_busy),
        .tx_busy(tx_busy), .uart_en(uart_en), .tx_en(tx_en), .rx_en(rx_en),
        .parity_mode(parity_mode), .stop_bits(stop_bits),
        .baud_div(baud_div), .irq(irq)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // Strobe monitor, sampled mid-cycle
    always @(negedge PCLK) begin
        if (tx_wr_en) begin
            tx_cnt  = tx_cnt + 1;
            last_wd = tx_wdata;
        end
        if (rx_rd_en) rx_cnt = rx_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One APB transfer; the stalling FIFO condition is released after rel_n stalls (0 = never)
    task automatic apb(input logic [7:0] addr, input logic wr, input logic [31:0] wdata,
                       input int rel_n, output logic [31:0] rdata, output logic err,
                       output int waits);
        logic done;
        done  = 1'b0;
        waits = 0;
        rdata = '0;
        err   = 1'b1;
        @(posedge PCLK); #1;
        PADDR = addr; PWRITE = wr; PWDATA = wdata; PSEL = 1'b1; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge PCLK);
            if (PREADY) begin
                rdata = PRDATA;
                err   = PSLVERR;
                done  = 1'b1;
            end else begin
                waits++;
            end
            @(posedge PCLK); #1;
            if (!done && waits == rel_n) begin
                tx_full  = 1'b0;
                rx_empty = 1'b0;
            end
        end
        if (!done) check("apb_done", 32'd0, 32'd1);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          w, t0, r0;

    initial begin
        PRESET = 1'b1; PADDR = '0; PSEL = 0; PENABLE = 0; PWRITE = 0; PWDATA = '0;
        tx_full = 0; rx_empty = 1; tx_level = 5'd3; rx_level = 5'd0; rx_rdata = 8'h00;
        rx_done = 0; tx_done = 0; rx_error = 0; rx_busy = 1; tx_busy = 0;
        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b0;
        @(negedge PCLK);

        // Reset values
        check("rst_pready",  {31'd0, PREADY}, 32'd1);
        check("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
        check("rst_prdata",  PRDATA, 32'd0);
        check("rst_irq",     {31'd0, irq}, 32'd0);
        check("rst_baud",    {16'd0, baud_div}, 32'h1B);
        check("rst_ctrl",    {26'd0, stop_bits, parity_mode, rx_en, tx_en, uart_en}, 32'd0);
        check("rst_wr_en",   {31'd0, tx_wr_en}, 32'd0);

        apb(8'h04, 0, 0, 0, rd, er, w); check("rd_ctrl", rd, 32'd0); check("rd_ctrl_err", {31'd0, er}, 0);
        apb(8'h14, 0, 0, 0, rd, er, w); check("rd_baud", rd, 32'h1B);
        apb(8'h18, 0, 0, 0, rd, er, w); check("rd_thr", rd, 32'h0000_0001);
        apb(8'h0C, 0, 0, 0, rd, er, w); check("rd_int_stat", rd, 32'd0);
        apb(8'h10, 0, 0, 0, rd, er, w); check("rd_int_en", rd, 32'd0);

        // STAT is live
        apb(8'h08, 0, 0, 0, rd, er, w); check("rd_stat_a", rd, 32'h0003_0005);
        rx_empty = 0; tx_full = 1; rx_busy = 0; tx_busy = 1; rx_level = 5'h10; tx_level = 5'h1F;
        apb(8'h08, 0, 0, 0, rd, er, w); check("rd_stat_b", rd, 32'h001F_100A);
        rx_empty = 1; tx_full = 0; rx_busy = 1; tx_busy = 0; rx_level = 5'd0; tx_level = 5'd3;

        // CTRL and BAUD
        apb(8'h04, 1, 32'h27, 0, rd, er, w);
        check("ctrl_out", {26'd0, stop_bits, parity_mode, rx_en, tx_en, uart_en}, 32'h27);
        apb(8'h14, 1, 32'h0, 0, rd, er, w); check("baud_zero_ignored", {16'd0, baud_div}, 32'h1B);
        apb(8'h14, 1, 32'h0100, 0, rd, er, w); check("baud_write", {16'd0, baud_div}, 32'h0100);

        // DATA write stalled 3 cycles
        t0 = tx_cnt; tx_full = 1;
        apb(8'h00, 1, 32'hA5, 3, rd, er, w);
        check("tx_stall_waits", w, 3);
        check("tx_stall_err", {31'd0, er}, 0);
        check("tx_stall_strobes", tx_cnt - t0, 1);
        check("tx_stall_wdata", {24'd0, last_wd}, 32'hA5);

        // DATA write without stall
        t0 = tx_cnt;
        apb(8'h00, 1, 32'h5A, 0, rd, er, w);
        check("tx_nostall_waits", w, 0);
        check("tx_nostall_strobes", tx_cnt - t0, 1);
        check("tx_nostall_wdata", {24'd0, last_wd}, 32'h5A);

        // DATA read timeout
        r0 = rx_cnt; rx_empty = 1;
        apb(8'h00, 0, 0, 0, rd, er, w);
        check("rx_to_waits", w, 15);
        check("rx_to_err", {31'd0, er}, 1);
        check("rx_to_prdata", rd, 0);
        check("rx_to_strobes", rx_cnt - r0, 0);
        apb(8'h0C, 0, 0, 0, rd, er, w); check("int_apb_err", rd, 32'h20);
        apb(8'h0C, 1, 32'h20, 0, rd, er, w);
        apb(8'h0C, 0, 0, 0, rd, er, w); check("int_w1c", rd, 32'h0);

        // DATA read success
        r0 = rx_cnt; rx_empty = 0; rx_rdata = 8'h3C;
        apb(8'h00, 0, 0, 0, rd, er, w);
        check("rx_ok_data", rd, 32'h3C);
        check("rx_ok_waits", w, 0);
        check("rx_ok_strobes", rx_cnt - r0, 1);
        rx_empty = 1;

        // Error responses
        apb(8'h1C, 0, 0, 0, rd, er, w);
        check("bad_1c_err", {31'd0, er}, 1); check("bad_1c_data", rd, 0); check("bad_1c_waits", w, 0);
        apb(8'h02, 0, 0, 0, rd, er, w);
        check("bad_02_err", {31'd0, er}, 1); check("bad_02_data", rd, 0);
        t0 = tx_cnt;
        apb(8'h15, 1, 32'h0777, 0, rd, er, w); check("bad_wr_err", {31'd0, er}, 1);
        apb(8'h01, 1, 32'h0011, 0, rd, er, w); check("bad_data_wr_err", {31'd0, er}, 1);
        check("bad_no_strobe", tx_cnt - t0, 0);
        check("bad_baud_kept", {16'd0, baud_div}, 32'h0100);
        apb(8'h04, 0, 0, 0, rd, er, w); check("bad_ctrl_kept", rd, 32'h27);
        apb(8'h08, 1, 32'hFFFF, 0, rd, er, w); check("wr_stat_no_err", {31'd0, er}, 0);
        apb(8'h0C, 0, 0, 0, rd, er, w); check("int_apb_err2", rd, 32'h20);
        apb(8'h0C, 1, 32'h3F, 0, rd, er, w);

        // Level bits: not sticky, immune to W1C
        apb(8'h18, 1, 32'h0004_0002, 0, rd, er, w);
        apb(8'h18, 0, 0, 0, rd, er, w); check("thr_rd", rd, 32'h0004_0002);
        rx_level = 5'd2; tx_level = 5'd3;
        apb(8'h0C, 0, 0, 0, rd, er, w); check("lvl_set", rd, 32'h18);
        apb(8'h0C, 1, 32'h18, 0, rd, er, w);
        apb(8'h0C, 0, 0, 0, rd, er, w); check("lvl_w1c_noeffect", rd, 32'h18);
        rx_level = 5'd0; tx_level = 5'd5;
        apb(8'h0C, 0, 0, 0, rd, er, w); check("lvl_clear", rd, 32'h0);
        apb(8'h18, 1, 32'h0, 0, rd, er, w);
        apb(8'h0C, 0, 0, 0, rd, er, w); check("rx_thr_zero", rd, 32'h08);
        apb(8'h18, 1, 32'h0004_0002, 0, rd, er, w);
        apb(8'h0C, 0, 0, 0, rd, er, w); check("lvl_clear2", rd, 32'h0);

        // irq latency and set-over-clear
        apb(8'h10, 1, 32'h01, 0, rd, er, w);
        @(negedge PCLK); check("irq_idle", {31'd0, irq}, 0);
        @(posedge PCLK); #1 rx_done = 1;
        @(posedge PCLK); #1 rx_done = 0;
        @(negedge PCLK); check("irq_n1", {31'd0, irq}, 0);
        @(negedge PCLK); check("irq_n2", {31'd0, irq}, 1);
        @(posedge PCLK); #1;
        PADDR = 8'h0C; PWRITE = 1; PWDATA = 32'h01; PSEL = 1; PENABLE = 0;
        @(posedge PCLK); #1;
        PENABLE = 1; rx_done = 1;
        @(negedge PCLK); check("w1c_race_ready", {31'd0, PREADY}, 1);
        @(posedge PCLK); #1;
        PSEL = 0; PENABLE = 0; rx_done = 0;
        apb(8'h0C, 0, 0, 0, rd, er, w); check("set_wins", rd, 32'h01);
        check("irq_still", {31'd0, irq}, 1);
        apb(8'h0C, 1, 32'h01, 0, rd, er, w);
        @(negedge PCLK); check("irq_w1c_m1", {31'd0, irq}, 1);
        @(negedge PCLK); check("irq_w1c_m2", {31'd0, irq}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_apb_regfile.md
Name: uart_apb_regfile

Overview:
Second-generation APB3 register file for the UART subsystem. It is parametrised in bus width, address width and FIFO depth. Compared with the first generation, it adds bounded wait states with timeout-to-PSLVERR, error response on bad addresses, a programmable baud divisor, FIFO level thresholds, and a maskable, registered interrupt output. It sits between the APB bus and the UART TX/RX FIFOs, the baud generator and the framers.

Parameters:
ADDR_WIDTH, 8, APB byte address width; registers are word-aligned.
DATA_WIDTH, 32, APB data width; legal values are 32 and 64; upper bits read 0.
FIFO_AW, 4, log2 of FIFO depth; level ports are FIFO_AW+1 bits wide; legal range 1..7.
WAIT_TIMEOUT, 15, maximum number of stalled access cycles on DATA before the transfer errors (1..255).

Ports:
PCLK  in  1  single clock
PRESET  in  1  reset; synchronous, active-high
PADDR  in  ADDR_WIDTH  APB address
PSEL  in  1  APB select
PENABLE  in  1  APB access phase
PWRITE  in  1  1=write, 0=read
PWDATA  in  DATA_WIDTH  write data
PREADY  out  1  transfer complete
PRDATA  out  DATA_WIDTH  read data
PSLVERR  out  1  error response
tx_full  in  1  TX FIFO full
tx_level  in  FIFO_AW+1  TX FIFO occupancy
tx_wr_en  out  1  TX FIFO push strobe
tx_wdata  out  8  TX FIFO push data
rx_empty  in  1  RX FIFO empty
rx_level  in  FIFO_AW+1  RX FIFO occupancy
rx_rdata  in  8  RX FIFO head data (first-word-fall-through)
rx_rd_en  out  1  RX FIFO pop strobe
rx_done  in  1  pulse: frame received
tx_done  in  1  pulse: frame sent
rx_error  in  1  pulse: framing/parity error
rx_busy  in  1  receiver active
tx_busy  in  1  transmitter active
uart_en  out  1  CTRL[0]
tx_en  out  1  CTRL[1]
rx_en  out  1  CTRL[2]
parity_mode  out  2  CTRL[4:3]: 0 none, 1 even, 2 odd, 3 reserved→none
stop_bits  out  1  CTRL[5]: 0 one, 1 two
baud_div  out  16  BAUD[15:0]
irq  out  1  registered interrupt

Behaviour:
- Interface: one clock; reset is synchronous and active-high. When PRESET=1 at a PCLK edge, all registers take their reset values, the wait counter clears and any in-flight transfer is abandoned with no FIFO strobe.
- Output reset values: PREADY=1, PRDATA=0, PSLVERR=0, tx_wr_en=0, rx_rd_en=0, tx_wdata=0, irq=0, CTRL outputs 0, baud_div=16'h001B.
- Register map:
  - 0x00 DATA: write pushes PWDATA[7:0]; read pops and returns rx_rdata.
  - 0x04 CTRL: RW, bits [5:0].
  - 0x08 STAT: RO. [0] rx_empty, [1] tx_full, [2] rx_busy, [3] tx_busy, [8+:FIFO_AW+1] rx_level, [16+:FIFO_AW+1] tx_level. All fields are live.
  - 0x0C INT_STAT: W1C.
  - 0x10 INT_EN: RW, bits [5:0].
  - 0x14 BAUD: RW. A write of 0 is ignored and the old value is kept.
  - 0x18 FIFO_THR: [FIFO_AW:0] rx_thr (reset 1), [16+FIFO_AW:16] tx_thr (reset 0).
- Access cycle: PSEL&PENABLE. PREADY, PRDATA and PSLVERR are combinational from the access cycle and wait counter. PRDATA=0 outside completing read cycles.
- Zero-wait completion: PREADY=1 in the first access cycle for all non-DATA addresses.
- Error completion: PREADY=1 with PSLVERR=1 in the first access cycle for an unmapped offset or PADDR[1:0]≠0. Error transfers have no side effects.
- Writes to STAT: ignored, PSLVERR=0.
- DATA stall: a DATA write with tx_full=1, or a DATA read with rx_empty=1, holds PREADY=0. wait_cnt increments once per stalled cycle.
- Stall resolution: when the FIFO condition clears, the transfer completes that cycle with PREADY=1 and a one-cycle strobe (tx_wr_en or rx_rd_en).
- Stall timeout: if wait_cnt==WAIT_TIMEOUT with the condition still present, the transfer completes with PREADY=1, PSLVERR=1 and no strobe. wait_cnt clears on any completion or when PSEL=0.
- Strobe timing: tx_wr_en and tx_wdata are asserted only in the completing cycle of a successful DATA write. rx_rd_en is asserted only in the completing cycle of a successful DATA read. Both are combinational and never asserted twice per transfer.
- INT_STAT bits:
  - [0] rx_done, [1] tx_done, [2] rx_error, [5] apb_err: sticky, set by the input pulse or, for [5], by any PSLVERR completion.
  - [3] rx_thr = (rx_level >= rx_thr) and [4] tx_thr = (tx_level <= tx_thr): level bits, registered, not sticky, and W1C has no effect on them.
- Set versus clear: a set event wins over a same-cycle W1C on the same bit.
- irq: registered as |(INT_STAT & INT_EN) & uart_en. An event pulse at cycle N is visible in INT_STAT at N+1 and on irq at N+2.
- Zero threshold: rx_thr=0 means rx_thr is permanently asserted; this is intentional.

Decomposition:
- Package uart_regs_pkg holds the register offsets, CTRL/STAT/INT bit indices, reset constants (BAUD_RST=16'h001B) and the parity_mode encoding.
- Sub-module uart_int_ctrl holds INT_STAT, INT_EN, the W1C/set-priority logic and the irq register.
- The APB decode and wait counter stay in the top level.

Test Plan:
- Reset, then read every register → CTRL=0, BAUD=0x1B, FIFO_THR=0x0000_0001, INT_STAT=0, irq=0, PSLVERR=0.
- Write CTRL=0x27, then BAUD=0x0000 → uart_en=tx_en=rx_en=1, parity_mode=0, stop_bits=1; baud_div stays 0x1B.
- DATA write 0xA5 with tx_full=1 for 3 cycles, then 0 → PREADY low for 3 cycles; single tx_wr_en with tx_wdata=0xA5 in cycle 4.
- DATA read with rx_empty held 1 and WAIT_TIMEOUT=15 → 15 stall cycles, then PREADY=1, PSLVERR=1, no rx_rd_en; INT_STAT[5]=1.
- Read at 0x1C and at 0x02 → PSLVERR=1 on zero wait, PRDATA=0, no register change.
- INT_EN=0x01, uart_en=1, rx_done pulse at cycle N → irq=1 at N+2. W1C 0x01 coinciding with a second rx_done → bit stays 1. Later W1C alone → irq=0 two cycles later.
